// File: rtl/axis_testpattern_pkg.sv
// Shared types and helpers for the AXI-Stream test pattern generator/checker pair.
// tp_next() gives the generator and the checker one definition of the wrapping counter.
package axis_testpattern_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } tp_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic signed [63:0] tp_sext(input logic signed [63:0] x,
                                                   input int                 width);
        return (x <<< (64 - width)) >>> (64 - width);
    endfunction

    // Counter values wrap at the stream width, so the threshold and the result are
    // both reinterpreted as signed numbers of that width before use.
    function automatic logic signed [63:0] tp_next(input logic signed [63:0] x,
                                                   input int                 width,
                                                   input longint             start_v,
                                                   input longint             end_v,
                                                   input longint             incr_v);
        logic signed [63:0] xs;
        logic signed [63:0] thr;
        logic signed [63:0] r;
        xs  = tp_sext(x, width);
        thr = tp_sext(end_v - incr_v + 64'sd1, width);
        if (xs >= thr)
            r = xs + incr_v - (end_v - start_v) - 64'sd1;
        else
            r = xs + incr_v;
        return tp_sext(r, width);
    endfunction

endpackage

// File: rtl/axis_tp_lfsr.sv
// 16-bit maximal-length LFSR used to throttle tready and exercise generator stalls.
module axis_tp_lfsr
    import axis_testpattern_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic gate
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign gate = lfsr[0];

endmodule

// File: rtl/axis_testpattern_checker.sv
// AXI-Stream checker for the wrapping counter stream of the test pattern generator.
// Optional feature: define AXIS_TESTPATTERN_CHECKER_BACKPRESSURE_EN to throttle tready with an LFSR.
module axis_testpattern_checker
    import axis_testpattern_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_START      = 0,
    parameter int COUNTER_END        = 255,
    parameter int COUNTER_INCR       = 1,
    parameter int ERR_CNT_WIDTH      = 16,
    parameter int RX_CNT_WIDTH       = 32,
    parameter int LOSS_THRESH        = 4
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          locked,
    output logic                          error,
    output logic [ERR_CNT_WIDTH-1:0]      err_count,
    output logic [ERR_CNT_WIDTH-1:0]      loss_count,
    output logic [RX_CNT_WIDTH-1:0]       rx_count,
    output logic [S_AXIS_TDATA_WIDTH-1:0] expected
);

    localparam int RUN_W = $clog2(LOSS_THRESH + 1);

    tp_state_t                     state;
    tp_state_t                     state_next;
    logic                          ready_q;
    logic                          error_q;
    logic                          acc;
    logic                          mismatch;
    logic                          lose;
    logic [RUN_W-1:0]              run;
    logic [RUN_W-1:0]              run_inc;
    logic [S_AXIS_TDATA_WIDTH-1:0] expected_q;
    logic [S_AXIS_TDATA_WIDTH-1:0] next_data;

`ifdef AXIS_TESTPATTERN_CHECKER_BACKPRESSURE_EN
    logic lfsr_gate;

    axis_tp_lfsr u_lfsr (
        .clk   (s_axis_aclk),
        .reset (s_axis_areset),
        .gate  (lfsr_gate)
    );

    assign s_axis_tready = ready_q && lfsr_gate;
`else
    assign s_axis_tready = ready_q;
`endif

    assign acc = s_axis_tvalid && s_axis_tready;

    // A matching beat equals expected, so next(tdata) serves both the match and resync cases.
    assign next_data = S_AXIS_TDATA_WIDTH'(tp_next(64'(s_axis_tdata), S_AXIS_TDATA_WIDTH,
                                                   longint'(COUNTER_START),
                                                   longint'(COUNTER_END),
                                                   longint'(COUNTER_INCR)));

    assign run_inc  = run + RUN_W'(1);
    assign mismatch = (state == LOCKED) && acc && (s_axis_tdata != expected_q);
    assign lose     = mismatch && (run_inc >= RUN_W'(LOSS_THRESH));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SYNC;
            SYNC:    if (acc) state_next = LOCKED;
            LOCKED:  if (lose) state_next = SYNC;
            default: state_next = IDLE;
        endcase
        if (!enable)
            state_next = IDLE;
        if (clear)
            state_next = enable ? SYNC : IDLE;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            run        <= '0;
            err_count  <= '0;
            loss_count <= '0;
            rx_count   <= '0;
            expected_q <= S_AXIS_TDATA_WIDTH'(COUNTER_START);
        end else begin
            state   <= state_next;
            ready_q <= enable && (state != IDLE);
            error_q <= mismatch && !clear;
            if (acc)
                expected_q <= next_data;
            // clear takes priority over any count produced by the same beat
            if (clear) begin
                run        <= '0;
                err_count  <= '0;
                loss_count <= '0;
                rx_count   <= '0;
            end else begin
                if (acc) begin
                    rx_count <= rx_count + RX_CNT_WIDTH'(1);
                    run      <= (mismatch && !lose) ? run_inc : '0;
                end
                if (mismatch && (err_count != '1))
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
                if (lose && (loss_count != '1))
                    loss_count <= loss_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign locked   = (state == LOCKED);
    assign error    = error_q;
    assign expected = expected_q;

endmodule
